// File: rtl/bridge_fanout.sv
// rtl/bridge_fanout.sv - one-to-N bridge fan-out with address decode and fixed-latency read capture
module bridge_fanout #(
    parameter int                         NUM_LEAVES      = 4,
    parameter logic [NUM_LEAVES*32-1:0]   ADDR_BASE       = {NUM_LEAVES{32'h0}},
    parameter logic [NUM_LEAVES*32-1:0]   ADDR_MASK       = {NUM_LEAVES{32'h0}},
    parameter int                         RD_LATENCY      = 2,
    parameter logic [31:0]                DEFAULT_RD_DATA = 32'hFFFF_FFFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  root_addr,
    input  logic [31:0]                  root_wr_data,
    input  logic                         root_wr,
    input  logic                         root_rd,
    output logic [31:0]                  root_rd_data,
    output logic                         root_rd_busy,
    output logic [31:0]                  leaf_addr,
    output logic [31:0]                  leaf_wr_data,
    output logic [NUM_LEAVES-1:0]        leaf_wr,
    output logic [NUM_LEAVES-1:0]        leaf_rd,
    input  logic [NUM_LEAVES*32-1:0]     leaf_rd_data
);

    localparam int SW = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic                  unmapped_q, unmapped_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  busy_q, busy_d;
    logic [31:0]           leaf_addr_q, leaf_addr_d;
    logic [31:0]           leaf_wr_data_q, leaf_wr_data_d;
    logic [NUM_LEAVES-1:0] leaf_wr_q, leaf_wr_d;
    logic [NUM_LEAVES-1:0] leaf_rd_q, leaf_rd_d;

    logic [SW-1:0]         dec_sel;
    logic                  dec_hit;
    logic [NUM_LEAVES-1:0] dec_onehot;
    logic [31:0]           sel_rd_data;

    // Scan from the top down so the lowest-index matching window wins.
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if ((root_addr & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
                dec_sel = SW'(i);
                dec_hit = 1'b1;
            end
        end
        dec_onehot = NUM_LEAVES'(1) << dec_sel;
    end

    always_comb begin
        sel_rd_data = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (sel_q == SW'(i)) begin
                sel_rd_data = leaf_rd_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        leaf_addr_d    = leaf_addr_q;
        leaf_wr_data_d = leaf_wr_data_q;
        leaf_wr_d      = '0;
        leaf_rd_d      = '0;
        state_d        = state_q;
        sel_d          = sel_q;
        unmapped_d     = unmapped_q;
        cnt_d          = cnt_q;
        rd_data_d      = rd_data_q;
        busy_d         = busy_q;

        if (root_wr || root_rd) begin
            leaf_addr_d    = root_addr;
            leaf_wr_data_d = root_wr_data;
        end
        if (dec_hit && root_wr) leaf_wr_d = dec_onehot;
        if (dec_hit && root_rd) leaf_rd_d = dec_onehot;

        // A new read always restarts the timer, discarding any read in flight.
        if (root_rd) begin
            sel_d      = dec_sel;
            unmapped_d = !dec_hit;
            cnt_d      = CW'(RD_LATENCY);
            state_d    = S_WAIT;
            busy_d     = 1'b1;
        end else if (state_q == S_WAIT) begin
            if (cnt_q == '0) begin
                rd_data_d = unmapped_q ? DEFAULT_RD_DATA : sel_rd_data;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sel_q          <= '0;
            unmapped_q     <= 1'b0;
            cnt_q          <= '0;
            rd_data_q      <= '0;
            busy_q         <= 1'b0;
            leaf_addr_q    <= '0;
            leaf_wr_data_q <= '0;
            leaf_wr_q      <= '0;
            leaf_rd_q      <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            unmapped_q     <= unmapped_d;
            cnt_q          <= cnt_d;
            rd_data_q      <= rd_data_d;
            busy_q         <= busy_d;
            leaf_addr_q    <= leaf_addr_d;
            leaf_wr_data_q <= leaf_wr_data_d;
            leaf_wr_q      <= leaf_wr_d;
            leaf_rd_q      <= leaf_rd_d;
        end
    end

    assign root_rd_data = rd_data_q;
    assign root_rd_busy = busy_q;
    assign leaf_addr    = leaf_addr_q;
    assign leaf_wr_data = leaf_wr_data_q;
    assign leaf_wr      = leaf_wr_q;
    assign leaf_rd      = leaf_rd_q;

endmodule

// File: tb/tb_bridge_fanout.sv
// tb/tb_bridge_fanout.sv - directed vector bench for bridge_fanout
module tb_bridge_fanout;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  root_addr;
    logic [31:0]  root_wr_data;
    logic         root_wr;
    logic         root_rd;
    logic [31:0]  ld [4];
    logic [127:0] leaf_rd_data;

    logic [31:0]  root_rd_data, leaf_addr, leaf_wr_data;
    logic         root_rd_busy;
    logic [3:0]   leaf_wr, leaf_rd;

    logic [31:0]  o_root_rd_data, o_leaf_addr, o_leaf_wr_data;
    logic         o_root_rd_busy;
    logic [3:0]   o_leaf_wr, o_leaf_rd;

    int tests = 0;
    int fails = 0;

    assign leaf_rd_data = {ld[3], ld[2], ld[1], ld[0]};

    always #5 clk = ~clk;

    bridge_fanout #(
        .NUM_LEAVES(4),
        .ADDR_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .ADDR_MASK({4{32'hF000_0000}})
    ) dut (
        .clk(clk), .reset(reset),
        .root_addr(root_addr), .root_wr_data(root_wr_data),
        .root_wr(root_wr), .root_rd(root_rd),
        .root_rd_data(root_rd_data), .root_rd_busy(root_rd_busy),
        .leaf_addr(leaf_addr), .leaf_wr_data(leaf_wr_data),
        .leaf_wr(leaf_wr), .leaf_rd(leaf_rd),
        .leaf_rd_data(leaf_rd_data)
    );

    // Leaves 0 and 2 share the 0x2xxx_xxxx window; nothing maps 0x0xxx_xxxx.
    bridge_fanout #(
        .NUM_LEAVES(4),
        .ADDR_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000}),
        .ADDR_MASK({4{32'hF000_0000}})
    ) dut_ovl (
        .clk(clk), .reset(reset),
        .root_addr(root_addr), .root_wr_data(root_wr_data),
        .root_wr(root_wr), .root_rd(root_rd),
        .root_rd_data(o_root_rd_data), .root_rd_busy(o_root_rd_busy),
        .leaf_addr(o_leaf_addr), .leaf_wr_data(o_leaf_wr_data),
        .leaf_wr(o_leaf_wr), .leaf_rd(o_leaf_rd),
        .leaf_rd_data(leaf_rd_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        rd;
        logic [3:0]  exp_wr;
        logic [3:0]  exp_rd;
        logic [3:0]  exp_ovl_wr;
        logic [3:0]  exp_ovl_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        root_wr = 1'b0;
        root_rd = 1'b0;
        root_addr = 32'h0;
        root_wr_data = 32'h0;
    endtask

    task automatic garbage();
        for (int i = 0; i < 4; i++) ld[i] = 32'hBAD0_0000 | 32'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] exp_data;

        vecs[0] = '{32'h2000_0010, 32'hA5A5_0001, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2] = '{32'h0000_0004, 32'h1111_0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[3] = '{32'h1000_0008, 32'h2222_0000, 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
        vecs[4] = '{32'h3000_000C, 32'h3333_0000, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
        vecs[5] = '{32'h8000_0000, 32'h4444_0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[6] = '{32'h2000_0020, 32'h5555_0000, 1'b1, 1'b1, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        garbage();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst_root_rd_data", root_rd_data, 32'h0);
        chk("rst_busy", {31'h0, root_rd_busy}, 32'h0);
        chk("rst_leaf_addr", leaf_addr, 32'h0);
        chk("rst_leaf_wr_data", leaf_wr_data, 32'h0);
        chk("rst_leaf_wr", {28'h0, leaf_wr}, 32'h0);
        chk("rst_leaf_rd", {28'h0, leaf_rd}, 32'h0);
        chk("rst_ovl_outputs", o_root_rd_data | o_leaf_addr | o_leaf_wr_data |
            {24'h0, o_leaf_wr, o_leaf_rd} | {31'h0, o_root_rd_busy}, 32'h0);
        step();
        reset = 1'b0;
        step();

        // Back-to-back vectors also cover strobes issued on consecutive cycles.
        exp_addr = 32'h0;
        exp_data = 32'h0;
        for (int i = 0; i < 8; i++) begin
            root_addr    = vecs[i].addr;
            root_wr_data = vecs[i].data;
            root_wr      = vecs[i].wr;
            root_rd      = vecs[i].rd;
            if (vecs[i].wr || vecs[i].rd) begin
                exp_addr = vecs[i].addr;
                exp_data = vecs[i].data;
            end
            step();
            chk($sformatf("v%0d_leaf_wr", i), {28'h0, leaf_wr}, {28'h0, vecs[i].exp_wr});
            chk($sformatf("v%0d_leaf_rd", i), {28'h0, leaf_rd}, {28'h0, vecs[i].exp_rd});
            chk($sformatf("v%0d_ovl_wr", i), {28'h0, o_leaf_wr}, {28'h0, vecs[i].exp_ovl_wr});
            chk($sformatf("v%0d_ovl_rd", i), {28'h0, o_leaf_rd}, {28'h0, vecs[i].exp_ovl_rd});
            chk($sformatf("v%0d_leaf_addr", i), leaf_addr, exp_addr);
            chk($sformatf("v%0d_leaf_wr_data", i), leaf_wr_data, exp_data);
        end
        idle_inputs();
        do_reset();

        // Mapped read to leaf 1; data valid only in cycle T+3.
        root_addr = 32'h1000_0004;
        root_rd = 1'b1;
        step();
        idle_inputs();
        chk("rd_t1_leaf_rd", {28'h0, leaf_rd}, 32'h2);
        chk("rd_t1_busy", {31'h0, root_rd_busy}, 32'h1);
        step();
        chk("rd_t2_leaf_rd", {28'h0, leaf_rd}, 32'h0);
        chk("rd_t2_busy", {31'h0, root_rd_busy}, 32'h1);
        step();
        ld[1] = 32'h1234_5678;
        chk("rd_t3_busy", {31'h0, root_rd_busy}, 32'h1);
        chk("rd_t3_data", root_rd_data, 32'h0);
        step();
        garbage();
        chk("rd_t4_busy", {31'h0, root_rd_busy}, 32'h0);
        chk("rd_t4_data", root_rd_data, 32'h1234_5678);
        step();
        chk("rd_t5_hold", root_rd_data, 32'h1234_5678);

        // Unmapped read returns the default word with the same latency.
        root_addr = 32'h8000_0000;
        root_rd = 1'b1;
        step();
        idle_inputs();
        chk("um_t1_leaf_rd", {28'h0, leaf_rd}, 32'h0);
        chk("um_t1_busy", {31'h0, root_rd_busy}, 32'h1);
        step();
        step();
        chk("um_t3_data", root_rd_data, 32'h1234_5678);
        chk("um_t3_busy", {31'h0, root_rd_busy}, 32'h1);
        step();
        chk("um_t4_data", root_rd_data, 32'hFFFF_FFFF);
        chk("um_t4_busy", {31'h0, root_rd_busy}, 32'h0);

        // Read to leaf 3 superseded at T+2 by a read to leaf 0.
        ld[3] = 32'hAAAA_0003;
        root_addr = 32'h3000_0000;
        root_rd = 1'b1;
        step();
        idle_inputs();
        chk("ov_t1_leaf_rd", {28'h0, leaf_rd}, 32'h8);
        step();
        root_addr = 32'h0000_0040;
        root_rd = 1'b1;
        step();
        idle_inputs();
        chk("ov_t3_leaf_rd", {28'h0, leaf_rd}, 32'h1);
        chk("ov_t3_busy", {31'h0, root_rd_busy}, 32'h1);
        step();
        chk("ov_t4_no_capture", root_rd_data, 32'hFFFF_FFFF);
        chk("ov_t4_busy", {31'h0, root_rd_busy}, 32'h1);
        step();
        ld[0] = 32'h0000_C0DE;
        chk("ov_t5_busy", {31'h0, root_rd_busy}, 32'h1);
        chk("ov_t5_data", root_rd_data, 32'hFFFF_FFFF);
        step();
        garbage();
        chk("ov_t6_data", root_rd_data, 32'h0000_C0DE);
        chk("ov_t6_busy", {31'h0, root_rd_busy}, 32'h0);

        // Asynchronous reset in the middle of a read.
        root_addr = 32'h2000_0008;
        root_wr_data = 32'h7777_0000;
        root_rd = 1'b1;
        step();
        idle_inputs();
        step();
        reset = 1'b1;
        #1;
        chk("mr_root_rd_data", root_rd_data, 32'h0);
        chk("mr_busy", {31'h0, root_rd_busy}, 32'h0);
        chk("mr_leaf_addr", leaf_addr, 32'h0);
        chk("mr_leaf_wr_data", leaf_wr_data, 32'h0);
        chk("mr_leaf_strobes", {24'h0, leaf_wr, leaf_rd}, 32'h0);
        ld[2] = 32'h5555_2222;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mr_post%0d_busy", i), {31'h0, root_rd_busy}, 32'h0);
            chk($sformatf("mr_post%0d_data", i), root_rd_data, 32'h0);
        end

        root_addr = 32'h2000_0008;
        root_rd = 1'b1;
        step();
        idle_inputs();
        chk("nr_t1_leaf_rd", {28'h0, leaf_rd}, 32'h4);
        chk("nr_t1_busy", {31'h0, root_rd_busy}, 32'h1);
        step();
        step();
        chk("nr_t3_data", root_rd_data, 32'h0);
        step();
        chk("nr_t4_data", root_rd_data, 32'h5555_2222);
        chk("nr_t4_busy", {31'h0, root_rd_busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
